// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and the source-select type for the CDB arbiter and its result queues.
package cdb_arbiter_pkg;

    localparam int ROB_SIZE_WIDTH       = 4;
    localparam int CDB_FIFO_DEPTH_WIDTH = 2;
    localparam int VALUE_WIDTH          = 32;
    localparam int ENTRY_WIDTH          = VALUE_WIDTH + ROB_SIZE_WIDTH;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_t;

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-source result queue: power-of-two ring buffer with occupancy count and flush.
// A push into a full queue is accepted only when the same cycle pops; otherwise it is dropped.
module result_fifo #(
    parameter int DEPTH_WIDTH = 2,
    parameter int DATA_WIDTH  = 36
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] head,
    output logic [DEPTH_WIDTH:0]  count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0]   FULL_COUNT = (DEPTH_WIDTH + 1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0]   COUNT_ONE  = (DEPTH_WIDTH + 1)'(1);
    localparam logic [DEPTH_WIDTH-1:0] PTR_ONE    = (DEPTH_WIDTH)'(1);

    logic [DATA_WIDTH-1:0]  slots [DEPTH];
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic                   full;
    logic                   do_push;
    logic                   do_pop;

    assign full     = (count == FULL_COUNT);
    assign do_pop   = pop && (count != '0);
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign head     = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues ALU and load results, grants one per cycle round-robin,
// and registers the winner onto the broadcast bus with one cycle of latency.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH_WIDTH = CDB_FIFO_DEPTH_WIDTH
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      need_flush_in,
    input  logic                      alu_valid_in,
    input  logic [31:0]               alu_value_in,
    input  logic [ROB_SIZE_WIDTH-1:0] alu_rob_id_in,
    input  logic                      mem_valid_in,
    input  logic [31:0]               mem_value_in,
    input  logic [ROB_SIZE_WIDTH-1:0] mem_rob_id_in,
    output logic                      alu_stall_out,
    output logic                      mem_stall_out,
    output logic                      cdb_valid,
    output logic [31:0]               cdb_value,
    output logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id,
    output logic                      overflow_err
);

    localparam int DEPTH = 1 << FIFO_DEPTH_WIDTH;
    localparam logic [FIFO_DEPTH_WIDTH:0] STALL_LEVEL = (FIFO_DEPTH_WIDTH + 1)'(DEPTH - 1);

    logic [ENTRY_WIDTH-1:0]    alu_head;
    logic [ENTRY_WIDTH-1:0]    mem_head;
    logic [FIFO_DEPTH_WIDTH:0] alu_count;
    logic [FIFO_DEPTH_WIDTH:0] mem_count;
    logic                      alu_overflow;
    logic                      mem_overflow;
    logic                      alu_empty;
    logic                      mem_empty;
    logic                      alu_cand;
    logic                      mem_cand;
    logic [ENTRY_WIDTH-1:0]    alu_cand_data;
    logic [ENTRY_WIDTH-1:0]    mem_cand_data;
    logic                      active;
    logic                      flush;
    logic                      grant_alu;
    logic                      grant_mem;
    logic                      alu_push;
    logic                      mem_push;
    logic                      alu_pop;
    logic                      mem_pop;
    src_t                      last_grant;

    assign active    = rdy_in && !need_flush_in;
    assign flush     = rdy_in && need_flush_in;
    assign alu_empty = (alu_count == '0);
    assign mem_empty = (mem_count == '0);

    // An empty queue lets the same-cycle input compete directly so lone results take one cycle.
    assign alu_cand      = alu_empty ? alu_valid_in : 1'b1;
    assign mem_cand      = mem_empty ? mem_valid_in : 1'b1;
    assign alu_cand_data = alu_empty ? {alu_value_in, alu_rob_id_in} : alu_head;
    assign mem_cand_data = mem_empty ? {mem_value_in, mem_rob_id_in} : mem_head;

    // Ties go to whichever source did not win the previous granted cycle.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (active) begin
            if (alu_cand && mem_cand) begin
                grant_alu = (last_grant == SRC_MEM);
                grant_mem = (last_grant == SRC_ALU);
            end else begin
                grant_alu = alu_cand;
                grant_mem = mem_cand;
            end
        end
    end

    assign alu_pop  = grant_alu && !alu_empty;
    assign mem_pop  = grant_mem && !mem_empty;
    assign alu_push = active && alu_valid_in && !(grant_alu && alu_empty);
    assign mem_push = active && mem_valid_in && !(grant_mem && mem_empty);

    assign alu_stall_out = (alu_count >= STALL_LEVEL);
    assign mem_stall_out = (mem_count >= STALL_LEVEL);

    result_fifo #(
        .DEPTH_WIDTH (FIFO_DEPTH_WIDTH),
        .DATA_WIDTH  (ENTRY_WIDTH)
    ) alu_queue (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (alu_push),
        .pop       (alu_pop),
        .flush     (flush),
        .push_data ({alu_value_in, alu_rob_id_in}),
        .head      (alu_head),
        .count     (alu_count),
        .overflow  (alu_overflow)
    );

    result_fifo #(
        .DEPTH_WIDTH (FIFO_DEPTH_WIDTH),
        .DATA_WIDTH  (ENTRY_WIDTH)
    ) mem_queue (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (mem_push),
        .pop       (mem_pop),
        .flush     (flush),
        .push_data ({mem_value_in, mem_rob_id_in}),
        .head      (mem_head),
        .count     (mem_count),
        .overflow  (mem_overflow)
    );

    // Bus register and round-robin pointer; a flush restores ALU-first tie breaking.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cdb_valid    <= 1'b0;
            cdb_value    <= '0;
            cdb_rob_id   <= '0;
            overflow_err <= 1'b0;
            last_grant   <= SRC_MEM;
        end else begin
            if (alu_overflow || mem_overflow) overflow_err <= 1'b1;
            if (flush) begin
                cdb_valid  <= 1'b0;
                last_grant <= SRC_MEM;
            end else if (!active) begin
                cdb_valid <= 1'b0;
            end else begin
                cdb_valid <= grant_alu || grant_mem;
                if (grant_alu) begin
                    {cdb_value, cdb_rob_id} <= alu_cand_data;
                    last_grant              <= SRC_ALU;
                end else if (grant_mem) begin
                    {cdb_value, cdb_rob_id} <= mem_cand_data;
                    last_grant              <= SRC_MEM;
                end
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH_WIDTH, default `CDB_FIFO_DEPTH_WIDTH (2), log2 of per-source queue depth (depth 4).
REQ-002 SHALL have port clk_in  input  1  single clock, all state on posedge.
REQ-003 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rdy_in  input  1  global enable; low = pause.
REQ-005 SHALL have port need_flush_in  input  1  mispredict flush.
REQ-006 SHALL have ports alu_valid_in / alu_value_in / alu_rob_id_in  input  1 / 32 / `ROB_SIZE_WIDTH  ALU result.
REQ-007 SHALL have ports mem_valid_in / mem_value_in / mem_rob_id_in  input  1 / 32 / `ROB_SIZE_WIDTH  load-unit result.
REQ-008 SHALL have ports alu_stall_out / mem_stall_out  output  1 / 1  per-source backpressure.
REQ-009 SHALL have ports cdb_valid / cdb_value / cdb_rob_id  output reg  1 / 32 / `ROB_SIZE_WIDTH  broadcast bus to RS, LSB, ROB.
REQ-010 SHALL have port overflow_err  output reg  1  sticky overflow flag.

Function
REQ-011 SHALL keep one FIFO per source, depth 2^FIFO_DEPTH_WIDTH, entry = {value, rob_id}.
REQ-012 SHALL form each source's candidate from its FIFO head if non-empty, else from the same-cycle valid input (bypass).
REQ-013 SHALL grant one candidate per cycle; only one present -> grant it; both present -> grant the source not granted last (round-robin bit last_grant).
REQ-014 SHALL register the granted {value, rob_id} on cdb_value/cdb_rob_id and set cdb_valid=1 in the cycle after grant; no candidate -> cdb_valid=0 next cycle. Latency from empty-queue input to bus: 1 cycle.
REQ-015 SHALL enqueue a valid input not consumed by bypass; pop head on grant; simultaneous push+pop leaves count unchanged.
REQ-016 SHALL preserve per-source order; the bus never carries a source's result ahead of an older result from the same source.
REQ-017 SHALL drive x_stall_out = 1 combinationally when that queue's count >= depth-1.
REQ-018 SHALL drop a push into a full queue, leave the queue unchanged and set overflow_err=1 until reset.
REQ-019 SHALL toggle last_grant only on a granted cycle.
REQ-020 SHALL, on need_flush_in=1 with rdy_in=1, empty both queues, set cdb_valid=0, set last_grant=MEM, ignore same-cycle inputs; flush wins over every simultaneous push/grant.
REQ-021 SHALL, on rdy_in=0, hold queues, counts and last_grant, set cdb_valid=0, ignore inputs.

Reset
REQ-022 SHALL on rst_in=1 (any state, mid-burst included): empty queues, cdb_valid=0, cdb_value=0, cdb_rob_id=0, overflow_err=0, last_grant=MEM (ALU wins first tie).
REQ-023 SHALL give rst_in priority over rdy_in and need_flush_in.

Structure
REQ-024 SHALL take ROB_SIZE_WIDTH and new CDB_FIFO_DEPTH_WIDTH from src/const_param.v.
REQ-025 SHALL implement queues as sub-module result_fifo (push, pop, flush, head, count), instantiated twice.
REQ-026 SHALL fit in 120-400 lines total; no latches, no multi-driven regs.

Verification
REQ-027 Lone ALU: alu_valid=1, value=0x11, rob=3 at cycle 0, idle otherwise -> cdb_valid=1, 0x11/3 at cycle 1, cdb_valid=0 at cycle 2.
REQ-028 Tie after reset: ALU 0xA/rob1 and MEM 0xB/rob2 in cycle 0 -> bus ALU(0xA,1) cycle 1, MEM(0xB,2) cycle 2.
REQ-029 Sustained contention: both sources valid 6 cycles, values ALU 1..6, MEM 101..106 -> bus alternates 1,101,2,102,...; mem_stall_out rises when MEM count reaches 3; all 12 delivered, in order per source.
REQ-030 Overflow: hold MEM priority while pushing 5 ALU results back-to-back ignoring stall -> 5th dropped, overflow_err=1 and remains until rst_in.
REQ-031 Flush: queue 3 ALU entries, need_flush_in=1 for one cycle -> cdb_valid=0 next cycle, queues empty, next lone input appears 1 cycle later.
REQ-032 Pause: rdy_in=0 for 3 cycles with 2 queued entries -> cdb_valid=0 throughout, entries emitted in order after rdy_in=1.
